counting_rr_sched: RTL

- Time-multiplexed "1-2-3" symbol-sequence detector shared by N_REQ independent requesters.
- Round-robin arbiter grants one requester per cycle to a single next-state engine.
- Per-requester detector state and saturating hit counters are kept in register arrays, so every channel sees an isolated detector.
- Sits between symbol producers and the status/reporting logic.

---
 rtl/counting_rr_sched_pkg.sv | 35 +++
 rtl/counting_rr_arb.sv | 39 +++
 rtl/counting_rr_sched.sv | 119 +++++++++++
 3 files changed

// File: rtl/counting_rr_sched_pkg.sv
// Shared definitions for the counting round-robin "1-2-3" sequence detector.
// Contents:
//   ST_W       - width of a detector state
//   state_t    - detector states S0..S3 (encoded 0..3)
//   next_state - next-state table applied when a symbol is consumed
//   is_hit     - true when a next state constitutes a sequence match
package counting_rr_sched_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // Symbol 0 holds the current state in every state.
  function automatic state_t next_state(input state_t state, input logic [1:0] num);
    state_t nxt;
    nxt = state;
    case (num)
      2'd1: nxt = S1;
      2'd2: nxt = (state == S1 || state == S2) ? S2 : S0;
      2'd3: nxt = (state == S2 || state == S3) ? S3 : S0;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

  function automatic logic is_hit(input state_t nxt);
    return (nxt == S3);
  endfunction

endpackage

// File: rtl/counting_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req_valid  - request vector
//   rr_ptr     - index with highest priority this cycle
//   grant      - one-hot grant (all-zero when nothing is requesting)
//   grant_idx  - index of the granted requester (0 when idle)
//   any_grant  - at least one request was granted
module counting_rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_grant
);

  localparam int IDX_W = $clog2(N_REQ);

  // Walking from rr_ptr upward with wrap is the rotate / priority-encode /
  // rotate-back structure folded into one loop; it also handles N_REQ that
  // is not a power of two.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % 32'(N_REQ);
      if (!any_grant && req_valid[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/counting_rr_sched.sv
// Time-multiplexed "1-2-3" sequence detector shared by N_REQ requesters.
// One requester per cycle is granted round-robin; its symbol runs through a
// single next-state engine while per-channel state and saturating hit
// counters live in register arrays.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_valid    - requester i has a symbol
//   req_num      - symbol of requester i at [2i+1:2i]
//   req_ready    - one-hot grant; symbol consumed on valid & ready
//   clr          - synchronous per-channel clear of state and counter
//   grant_id     - registered index of the last grant
//   hit_valid    - one-cycle pulse, a sequence match occurred
//   hit_id       - channel of the match (valid with hit_valid)
//   match_level  - high while channel i is in S3
//   hit_cnt      - hit counter of channel i at [(i+1)*CNT_W-1:i*CNT_W]
module counting_rr_sched
  import counting_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_num,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         clr,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     hit_valid,
  output logic [$clog2(N_REQ)-1:0] hit_id,
  output logic [N_REQ-1:0]         match_level,
  output logic [N_REQ*CNT_W-1:0]   hit_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           st  [N_REQ];
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gidx;
  logic             any_grant;

  logic [1:0]       g_num;
  state_t           g_state;
  state_t           g_next;
  logic             g_clr;
  logic             g_hit;

  counting_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .any_grant (any_grant)
  );

  assign req_ready = rst_n ? grant : '0;

  // Shared next-state engine working on the granted channel.
  always_comb begin
    g_num   = 2'd0;
    g_state = S0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        g_num   = req_num[2*i +: 2];
        g_state = st[i];
      end
    end
    g_next = next_state(g_state, g_num);
    g_clr  = |(clr & grant);
    // A zero symbol holds S3 but is not a new match.
    g_hit  = any_grant && !g_clr && (g_num != 2'd0) && is_hit(g_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      hit_valid <= 1'b0;
      hit_id    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        st[i]  <= S0;
        cnt[i] <= '0;
      end
    end else begin
      if (any_grant) begin
        grant_id <= gidx;
        rr_ptr   <= (gidx == IDX_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
      end
      hit_valid <= g_hit;
      if (g_hit) begin
        hit_id <= gidx;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (clr[i]) begin
          st[i]  <= S0;
          cnt[i] <= '0;
        end else if (grant[i]) begin
          st[i] <= g_next;
          if (g_hit && cnt[i] != '1) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    match_level = '0;
    hit_cnt     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      match_level[i]            = (st[i] == S3);
      hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

endmodule
